// File: rtl/dvi_timing_gen_pkg.sv
// rtl/dvi_timing_gen_pkg.sv - shared video timing defaults and raster FSM state encoding
//
// Purpose : timing constants for the 640x480@60 and 1024x768@60 modes,
//           and the WAIT_INIT/IDLE/RUN state type used by the timing generator.
// Ports   : none (package).
package dvi_timing_gen_pkg;

  // 640x480 @ 60 Hz, 25.175 MHz pixel clock
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;

  // 1024x768 @ 60 Hz, 65 MHz pixel clock
  localparam int XGA1024_H_ACTIVE = 1024;
  localparam int XGA1024_H_FP     = 24;
  localparam int XGA1024_H_SYNC   = 136;
  localparam int XGA1024_H_BP     = 160;
  localparam int XGA1024_V_ACTIVE = 768;
  localparam int XGA1024_V_FP     = 3;
  localparam int XGA1024_V_SYNC   = 6;
  localparam int XGA1024_V_BP     = 29;

  typedef enum logic [1:0] {
    WAIT_INIT = 2'd0,
    IDLE      = 2'd1,
    RUN       = 2'd2
  } tg_state_e;

endpackage

// File: rtl/dvi_timing_gen_sync_2ff.sv
// rtl/dvi_timing_gen_sync_2ff.sv - generic two-flop synchronizer, reset to 0
//
// Purpose : bring a single asynchronous level into the Clk domain.
// Ports   : Clk     in  clock of the destination domain
//           Reset_n in  synchronous active-low reset, clears both flops
//           d       in  asynchronous input level
//           q       out synchronized level (2 cycles of latency)
module sync_2ff (
  input  logic Clk,
  input  logic Reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dvi_timing_gen.sv
// rtl/dvi_timing_gen.sv - raster timing generator gated by encoder init-done
//
// Purpose : holds syncs inactive until the DVI encoder reports init done, then
//           generates Hsync/Vsync/De, pixel coordinates and a one-cycle-early
//           pixel fetch request. Clk is the pixel clock.
// Ports   : Clk, Reset_n          pixel clock, synchronous active-low reset
//           Init_done             encoder configured (asynchronous, synchronized here)
//           Enable                request raster output (frames always complete)
//           Pixel_valid           FIFO has data for the current De pixel
//           Pixel_req             fetch strobe, one cycle ahead of De
//           Hsync, Vsync          syncs, asserted level HSYNC_POL / VSYNC_POL
//           De, X, Y              active video and its coordinates (0 when De low)
//           Frame_start           pulse with the first De of each frame
//           Underflow             sticky: De seen while Pixel_valid low
module dvi_timing_gen
  import dvi_timing_gen_pkg::*;
#(
  parameter int   H_ACTIVE  = VGA640_H_ACTIVE,
  parameter int   H_FP      = VGA640_H_FP,
  parameter int   H_SYNC    = VGA640_H_SYNC,
  parameter int   H_BP      = VGA640_H_BP,
  parameter int   V_ACTIVE  = VGA640_V_ACTIVE,
  parameter int   V_FP      = VGA640_V_FP,
  parameter int   V_SYNC    = VGA640_V_SYNC,
  parameter int   V_BP      = VGA640_V_BP,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0,
  parameter int   CNT_W     = 12
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Init_done,
  input  logic             Enable,
  input  logic             Pixel_valid,
  output logic             Pixel_req,
  output logic             Hsync,
  output logic             Vsync,
  output logic             De,
  output logic [CNT_W-1:0] X,
  output logic [CNT_W-1:0] Y,
  output logic             Frame_start,
  output logic             Underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  tg_state_e        state, state_nxt;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             init_s;
  logic             run_ok;
  logic             h_last, frame_end;
  logic             act, hs, vs;

  sync_2ff u_init_sync (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .d       (Init_done),
    .q       (init_s)
  );

  // Qualifying with init_s blanks the decode in the same cycle the FSM is
  // forced back to WAIT_INIT, so no sync pulse or De is extended on exit.
  assign run_ok    = (state == RUN) && init_s;
  assign h_last    = (h_cnt == H_LAST);
  assign frame_end = h_last && (v_cnt == V_LAST);

  assign act = run_ok && (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
  assign hs  = run_ok && (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign vs  = run_ok && (v_cnt >= VS_BEG) && (v_cnt < VS_END);

  assign Pixel_req = act;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state <= WAIT_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      WAIT_INIT: if (init_s) state_nxt = IDLE;
      IDLE:      if (Enable) state_nxt = RUN;
      RUN:       if (frame_end && !Enable) state_nxt = IDLE;
      default:   state_nxt = WAIT_INIT;
    endcase
    if (!init_s) begin
      state_nxt = WAIT_INIT;
    end
  end

  // Counters only advance while staying in RUN; any other path lands on 0,
  // which also guarantees a fresh frame origin on every RUN entry.
  always_ff @(posedge Clk) begin
    if (!Reset_n || (state != RUN) || (state_nxt != RUN)) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_last ? '0 : h_cnt + CNT_W'(1);
      if (h_last) begin
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      De          <= 1'b0;
      X           <= '0;
      Y           <= '0;
      Frame_start <= 1'b0;
      Hsync       <= ~HSYNC_POL;
      Vsync       <= ~VSYNC_POL;
      Underflow   <= 1'b0;
    end else begin
      De          <= act;
      X           <= act ? h_cnt : '0;
      Y           <= act ? v_cnt : '0;
      Frame_start <= act && (h_cnt == '0) && (v_cnt == '0);
      Hsync       <= hs ? HSYNC_POL : ~HSYNC_POL;
      Vsync       <= vs ? VSYNC_POL : ~VSYNC_POL;
      Underflow   <= Underflow | (De & ~Pixel_valid);
    end
  end

endmodule

// File: tb/tb_dvi_timing_gen.sv
// tb/tb_dvi_timing_gen.sv - self-checking bench for dvi_timing_gen with a frame-position model
module tb_dvi_timing_gen;

  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic        Clk = 1'b0;
  logic        Reset_n, Init_done, Enable, Pixel_valid;
  logic        Pixel_req, Hsync, Vsync, De, Frame_start, Underflow;
  logic [11:0] X, Y;

  dvi_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CNT_W(12)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Init_done(Init_done), .Enable(Enable),
    .Pixel_valid(Pixel_valid), .Pixel_req(Pixel_req), .Hsync(Hsync), .Vsync(Vsync),
    .De(De), .X(X), .Y(Y), .Frame_start(Frame_start), .Underflow(Underflow)
  );

  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Model: raster described by mode and linear position inside the frame.
  bit          m_s1, m_s2;
  int          m_mode;            // 0 waiting for init, 1 idle, 2 running
  int          m_pos;
  bit          m_de, m_fs, m_hsync, m_vsync, m_uf;
  logic [11:0] m_x, m_y;

  bit stats_on = 0;
  int last_fs = -1, cnt_de = 0, cnt_hl = 0, cnt_vl = 0;

  function automatic bit pos_active(int pos);
    return ((pos % HT) < HA) && ((pos / HT) < VA);
  endfunction

  function automatic bit m_req();
    return (m_mode == 2) && m_s2 && pos_active(m_pos);
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    int h, v, nmode;
    bit live;
    if (!Reset_n) begin
      m_s1 = 0; m_s2 = 0; m_mode = 0; m_pos = 0;
      m_de = 0; m_fs = 0; m_hsync = 1; m_vsync = 1; m_uf = 0; m_x = 0; m_y = 0;
      return;
    end
    h    = m_pos % HT;
    v    = m_pos / HT;
    live = (m_mode == 2) && m_s2;
    m_uf    = m_uf | (m_de & ~Pixel_valid);
    m_de    = live && pos_active(m_pos);
    m_x     = m_de ? 12'(h) : 12'd0;
    m_y     = m_de ? 12'(v) : 12'd0;
    m_fs    = m_de && (m_pos == 0);
    m_hsync = !(live && h >= HA + HF && h < HA + HF + HS);
    m_vsync = !(live && v >= VA + VF && v < VA + VF + VS);
    if (!m_s2)            nmode = 0;
    else if (m_mode == 0) nmode = 1;
    else if (m_mode == 1) nmode = Enable ? 2 : 1;
    else                  nmode = (m_pos == FRAME - 1 && !Enable) ? 1 : 2;
    m_pos  = (m_mode == 2 && nmode == 2) ? (m_pos + 1) % FRAME : 0;
    m_mode = nmode;
    m_s2   = m_s1;
    m_s1   = Init_done;
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge Clk);
      model_edge();
      #1;
      cyc++;
      check($sformatf("outputs@cyc%0d", cyc),
            {2'b0, Pixel_req, Hsync, Vsync, De, Frame_start, Underflow, X, Y},
            {2'b0, m_req(), m_hsync, m_vsync, m_de, m_fs, m_uf, m_x, m_y});
      if (stats_on) begin
        if (Frame_start) begin
          if (last_fs >= 0) begin
            check("frame_period", cyc - last_fs, FRAME);
            check("de_per_frame", cnt_de, HA * VA);
            check("hsync_low_per_frame", cnt_hl, HS * VT);
            check("vsync_low_per_frame", cnt_vl, VS * HT);
          end
          last_fs = cyc; cnt_de = 0; cnt_hl = 0; cnt_vl = 0;
        end
        cnt_de += int'(De);
        cnt_hl += int'(!Hsync);
        cnt_vl += int'(!Vsync);
      end
    end
  endtask

  initial begin
    int target, i, gap;
    Reset_n = 0; Init_done = 0; Enable = 1; Pixel_valid = 1;
    step(3);
    check("reset_hsync", Hsync, 1);
    check("reset_de", De, 0);
    Reset_n = 1;

    // encoder not ready: raster must stay blank
    step(100);
    check("noinit_vsync", Vsync, 1);

    // init done: start-up and steady frames with per-frame statistics
    Init_done = 1;
    step(8);
    stats_on = 1; last_fs = -1;
    step(3 * FRAME + 10);
    stats_on = 0;

    // drop Enable on line 2; the frame must complete, then idle
    target = 2 * HT + int'($urandom_range(0, HT - 1));
    for (i = 0; i < 2 * FRAME && !(m_mode == 2 && m_pos == target); i++) step(1);
    check("en_drop_reached", (m_mode == 2 && m_pos == target), 1);
    Enable = 0;
    for (i = 0; i < 2 * FRAME && m_mode != 1; i++) step(1);
    check("en_drop_idle_reached", m_mode, 1);
    step(int'($urandom_range(5, 40)));
    check("idle_de", De, 0);
    check("idle_vsync", Vsync, 1);
    Enable = 1;
    step(2 * HT);

    // drop Init_done mid-line; within 3 cycles everything is inactive
    step(int'($urandom_range(20, 100)));
    Init_done = 0;
    step(3);
    check("initdrop_de", De, 0);
    check("initdrop_hsync", Hsync, 1);
    check("initdrop_vsync", Vsync, 1);
    step(10);
    Init_done = 1;
    step(FRAME + 20);

    // one De cycle without FIFO data sets sticky Underflow
    for (i = 0; i < 2 * FRAME && !m_de; i++) step(1);
    check("uf_de_reached", De, 1);
    Pixel_valid = 0;
    step(1);
    Pixel_valid = 1;
    check("uf_set", Underflow, 1);
    step(60);
    check("uf_sticky", Underflow, 1);
    Reset_n = 0;
    step(2);
    check("uf_reset", Underflow, 0);
    Reset_n = 1;

    // randomized Enable / Init_done / Pixel_valid activity
    Init_done = 1;
    for (i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 63) == 0)  Enable = !Enable;
      if ($urandom_range(0, 399) == 0) Init_done = !Init_done;
      Pixel_valid = ($urandom_range(0, 31) != 0);
      gap = 1;
      step(gap);
    end
    Init_done = 1; Enable = 1; Pixel_valid = 1;
    step(FRAME);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
